button_repeat_detector: RTL and testbench



---
 rtl/button_repeat_detector_pkg.sv | 23 ++
 rtl/button_repeat_detector_input_synchronizer.sv | 24 ++
 rtl/button_repeat_detector.sv | 129 ++++++++++++
 tb/tb_button_repeat_detector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_repeat_detector_pkg.sv
// Shared state encodings and default timing constants for the pushbutton
// press/repeat detector. The up/down counter bench reuses these values.
package button_repeat_detector_pkg;

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    DEBOUNCE_PRESS   = 3'd1,
    HELD_DELAY       = 3'd2,
    HELD_REPEAT      = 3'd3,
    DEBOUNCE_RELEASE = 3'd4
  } buttonState_t;

  localparam int unsigned DEBOUNCE_TICKS_DEFAULT = 8;
  localparam int unsigned REPEAT_DELAY_DEFAULT   = 500;
  localparam int unsigned REPEAT_PERIOD_DEFAULT  = 100;
  localparam int unsigned TIMER_BITS_DEFAULT     = 10;

  // True while the button counts as held, including the release debounce.
  function automatic logic isHeldState(input buttonState_t s);
    return (s == HELD_DELAY) || (s == HELD_REPEAT) || (s == DEBOUNCE_RELEASE);
  endfunction

endpackage

// File: rtl/button_repeat_detector_input_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs (buttons, dip switches).
module input_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  logic [WIDTH-1:0] stage1;

  // Two register stages; the second stage is the only one used downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage1  <= '0;
      syncOut <= '0;
    end else begin
      stage1  <= asyncIn;
      syncOut <= stage1;
    end
  end

endmodule

// File: rtl/button_repeat_detector.sv
// Debounced pushbutton press detector with hold-to-auto-repeat. Each accepted
// press (and each repeat while held) raises a request on wasPressed that is
// held until the consumer acknowledges it; requests raised while one is
// still pending are dropped.
module button_repeat_detector
  import button_repeat_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
  parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD  = REPEAT_PERIOD_DEFAULT,
  parameter bit          REPEAT_ENABLE  = 1'b1,
  parameter int unsigned TIMER_BITS     = TIMER_BITS_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic buttonDown,
  input  logic ackPress,
  output logic wasPressed,
  output logic isHeld
);

  localparam logic [TIMER_BITS-1:0] debounceLimit = TIMER_BITS'(DEBOUNCE_TICKS);
  localparam logic [TIMER_BITS-1:0] delayLimit    = TIMER_BITS'(REPEAT_DELAY);
  localparam logic [TIMER_BITS-1:0] periodLimit   = TIMER_BITS'(REPEAT_PERIOD);
  localparam logic [TIMER_BITS-1:0] timerOne      = TIMER_BITS'(1);

  buttonState_t          state;
  buttonState_t          stateNext;
  logic [TIMER_BITS-1:0] timer;
  logic [TIMER_BITS-1:0] timerNext;
  logic                  bSync;
  logic                  raise;
  logic                  wasPressedNext;

  input_synchronizer #(
    .WIDTH(1)
  ) buttonSync (
    .clock  (clock),
    .reset_n(reset_n),
    .asyncIn(buttonDown),
    .syncOut(bSync)
  );

  // Next-state, shared-timer and request-raise decisions from the synchronized level.
  always_comb begin
    stateNext = state;
    timerNext = timer;
    raise     = 1'b0;
    case (state)
      IDLE: begin
        if (bSync) begin
          stateNext = DEBOUNCE_PRESS;
          timerNext = timerOne;
        end
      end
      DEBOUNCE_PRESS: begin
        if (!bSync) begin
          stateNext = IDLE;
        end else if (timer == debounceLimit) begin
          stateNext = HELD_DELAY;
          timerNext = timerOne;
          raise     = 1'b1;
        end else begin
          timerNext = timer + timerOne;
        end
      end
      HELD_DELAY: begin
        if (!bSync) begin
          stateNext = DEBOUNCE_RELEASE;
          timerNext = timerOne;
        end else if (REPEAT_ENABLE && (timer == delayLimit)) begin
          stateNext = HELD_REPEAT;
          timerNext = timerOne;
          raise     = 1'b1;
        end else if (timer != delayLimit) begin
          // Without auto-repeat the timer parks at the delay value.
          timerNext = timer + timerOne;
        end
      end
      HELD_REPEAT: begin
        if (!bSync) begin
          stateNext = DEBOUNCE_RELEASE;
          timerNext = timerOne;
        end else if (timer == periodLimit) begin
          timerNext = timerOne;
          raise     = 1'b1;
        end else begin
          timerNext = timer + timerOne;
        end
      end
      DEBOUNCE_RELEASE: begin
        if (bSync) begin
          stateNext = REPEAT_ENABLE ? HELD_REPEAT : HELD_DELAY;
          timerNext = timerOne;
        end else if (timer == debounceLimit) begin
          stateNext = IDLE;
          timerNext = '0;
        end else begin
          timerNext = timer + timerOne;
        end
      end
      default: begin
        stateNext = IDLE;
        timerNext = '0;
      end
    endcase
  end

  // Pending request: an ack always wins, a raise only lands when nothing is pending.
  always_comb begin
    wasPressedNext = wasPressed ? !ackPress : raise;
  end

  // State, timer and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      wasPressed <= 1'b0;
      isHeld     <= 1'b0;
    end else begin
      state      <= stateNext;
      timer      <= timerNext;
      wasPressed <= wasPressedNext;
      isHeld     <= isHeldState(stateNext);
    end
  end

endmodule

// File: tb/tb_button_repeat_detector.sv
// Directed bench for button_repeat_detector with a behavioural reference model
// compared on every falling clock edge, plus literal request/release timing pins.
module tb_button_repeat_detector;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int P  = 8;
  localparam bit EN = 1'b1;

  logic clock;
  logic reset_n;
  logic buttonDown;
  logic ackPress;
  logic wasPressed;
  logic isHeld;

  int checks = 0;
  int fails  = 0;

  button_repeat_detector #(
    .DEBOUNCE_TICKS(D),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (P),
    .REPEAT_ENABLE (EN),
    .TIMER_BITS    (10)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .buttonDown(buttonDown),
    .ackPress  (ackPress),
    .wasPressed(wasPressed),
    .isHeld    (isHeld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // accepted: button considered held. highRun counts consecutive high samples
  // while not accepted; lowRun counts consecutive low samples while accepted;
  // sinceEvt counts held cycles since the last press/repeat/glitch event.
  logic mS1, mS2;
  bit   mAcc, mPend, mRep;
  int   highRun, lowRun, sinceEvt;
  int   edgeNo = 0;
  int   raiseEdges[$];
  int   fallEdge = -1;

  initial begin
    bit b, raise;
    mS1 = 0; mS2 = 0; mAcc = 0; mPend = 0; mRep = 0;
    highRun = 0; lowRun = 0; sinceEvt = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        mS1 = 0; mS2 = 0; mAcc = 0; mPend = 0; mRep = 0;
        highRun = 0; lowRun = 0; sinceEvt = 0;
      end else begin
        b = mS2;
        raise = 0;
        if (!mAcc) begin
          if (b) begin
            highRun++;
            if (highRun == D + 1) begin
              mAcc = 1; highRun = 0; lowRun = 0; sinceEvt = 1; mRep = 0; raise = 1;
            end
          end else begin
            highRun = 0;
          end
        end else if (!b) begin
          lowRun++;
          if (lowRun == D + 1) begin
            mAcc = 0; lowRun = 0; fallEdge = edgeNo;
          end
        end else if (lowRun > 0) begin
          lowRun = 0; sinceEvt = 1; mRep = EN;
        end else if (mRep ? (sinceEvt == P) : (EN && sinceEvt == RD)) begin
          sinceEvt = 1; mRep = 1; raise = 1;
        end else if (mRep || sinceEvt < RD) begin
          sinceEvt++;
        end
        if (mPend) begin
          if (ackPress) mPend = 0;
        end else if (raise) begin
          mPend = 1;
          raiseEdges.push_back(edgeNo);
        end
        mS2 = mS1;
        mS1 = buttonDown;
        edgeNo++;
      end
    end
  end

  // Every falling edge: DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clock);
      check("wasPressed", wasPressed, mPend);
      check("isHeld", isHeld, mAcc);
    end
  end

  // ---------------- stimulus ----------------
  int e0;

  // ackMode: 0 = no ack, 1 = echo wasPressed, 2 = force ack high
  task automatic step(input logic b, input int ackMode);
    buttonDown = b;
    ackPress   = (ackMode == 2) ? 1'b1 : ((ackMode == 1) ? wasPressed : 1'b0);
    @(negedge clock);
  endtask

  task automatic startScenario();
    raiseEdges.delete();
    fallEdge = -1;
    e0 = edgeNo;
  endtask

  task automatic checkRaises(input string name, input int n, input int e[5]);
    check({name, " count"}, raiseEdges.size(), n);
    for (int i = 0; i < n && i < raiseEdges.size(); i++)
      check({name, " edge"}, raiseEdges[i] - e0, e[i]);
  endtask

  initial begin
    int expClean[5]  = '{6, 0, 0, 0, 0};
    int expRepeat[5] = '{6, 26, 34, 42, 50};
    int expGlitch[5] = '{6, 26, 42, 0, 0};

    reset_n = 1'b0; buttonDown = 1'b0; ackPress = 1'b0;
    repeat (3) @(negedge clock);
    check("reset wasPressed", wasPressed, 0);
    check("reset isHeld", isHeld, 0);
    reset_n = 1'b1;
    repeat (5) step(0, 0);

    // clean press with echoed ack
    startScenario();
    repeat (6) step(1, 1);
    check("clean isHeld before accept", isHeld, 0);
    step(1, 1);
    check("clean isHeld at accept", isHeld, 1);
    check("clean wasPressed at accept", wasPressed, 1);
    step(1, 1);
    check("clean ack clears", wasPressed, 0);
    repeat (4) step(1, 1);
    repeat (12) step(0, 1);
    checkRaises("clean", 1, expClean);
    check("clean release edge", fallEdge - e0, 18);

    // bounce: never stable long enough
    startScenario();
    repeat (3) step(1, 1);
    step(0, 1);
    repeat (2) step(1, 1);
    repeat (12) step(0, 1);
    check("bounce raises", raiseEdges.size(), 0);
    check("bounce isHeld", isHeld, 0);
    check("bounce never held", fallEdge, -1);

    // auto-repeat with prompt ack
    startScenario();
    repeat (50) step(1, 1);
    repeat (12) step(0, 1);
    checkRaises("repeat", 5, expRepeat);
    check("repeat release edge", fallEdge - e0, 56);

    // no ack: single pending request survives release
    startScenario();
    repeat (50) step(1, 0);
    repeat (10) step(0, 0);
    check("noack pending", wasPressed, 1);
    step(0, 2);
    check("noack cleared", wasPressed, 0);
    repeat (10) step(0, 0);
    checkRaises("noack", 1, expClean);

    // release glitch
    startScenario();
    repeat (30) step(1, 1);
    repeat (2) step(0, 1);
    repeat (10) step(1, 1);
    repeat (12) step(0, 1);
    checkRaises("glitch", 3, expGlitch);

    // reset while held with a pending request
    startScenario();
    repeat (12) step(1, 0);
    check("midreset pending", wasPressed, 1);
    buttonDown = 1'b1;
    ackPress   = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midreset wasPressed", wasPressed, 0);
    check("midreset isHeld", isHeld, 0);
    @(negedge clock);
    repeat (3) step(0, 0);
    reset_n = 1'b1;
    repeat (4) step(0, 0);
    startScenario();
    repeat (12) step(1, 1);
    repeat (12) step(0, 1);
    checkRaises("afterreset", 1, expClean);
    check("afterreset release edge", fallEdge - e0, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
